// File: rtl/iic_tx_ack_engine.sv
// I2C transmit-and-acknowledge engine: shifts a burst of words onto SDA,
// MSB first, timed by the SCL phase strobes, and checks the slave ACK after
// every word. Reports done or nack back to the command sequencer.
// Optional build macro IIC_NACK_RETRY_EN: on a NACK the same word is resent
// from an internal copy up to MAX_RETRY times before nack is reported.
`timescale 1ns/1ps
module iic_tx_ack_engine #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BYTES = 4,
    parameter int unsigned LEN_W     = 3,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    input  logic              scl_lc,
    input  logic              scl_hc,
    input  logic              scl_fe,
    input  logic              sda_in,
    output logic              sda_out,
    output logic              sda_oe,
    output logic              busy,
    output logic              done,
    output logic              nack,
    output logic [LEN_W-1:0]  bytes_sent
);

    localparam int unsigned BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
`ifdef IIC_NACK_RETRY_EN
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`endif

    // Elaboration-time sanity check of the parameter set
    if ((MAX_BYTES == 0) || (LEN_W < $clog2(MAX_BYTES + 1)) || (MAX_RETRY > 255)) begin : g_bad_cfg
        $error("iic_tx_ack_engine: inconsistent parameters");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [BCNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic                armed_q, armed_d;
    logic                ackbit_q, ackbit_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    bytes_sent_q, bytes_sent_d;
    logic                sda_out_q, sda_out_d;
    logic                sda_oe_q, sda_oe_d;
    logic                tx_ready_q, tx_ready_d;
    logic                done_q, done_d;
    logic                nack_q, nack_d;
    logic                busy_q, busy_d;
    logic [LEN_W-1:0]    bytes_inc;
`ifdef IIC_NACK_RETRY_EN
    logic [DATA_W-1:0]   copy_q, copy_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
`endif

    assign bytes_inc = bytes_sent_q + LEN_W'(1);

    // Next-state and output decode; abort overrides every strobe
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        armed_d      = armed_q;
        ackbit_d     = ackbit_q;
        len_d        = len_q;
        bytes_sent_d = bytes_sent_q;
        sda_out_d    = sda_out_q;
        sda_oe_d     = sda_oe_q;
        tx_ready_d   = 1'b0;
        done_d       = 1'b0;
        nack_d       = 1'b0;
`ifdef IIC_NACK_RETRY_EN
        copy_d       = copy_q;
        retry_d      = retry_q;
`endif
        if (abort) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            armed_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    sda_oe_d = 1'b0;
                    if (start) begin
                        bytes_sent_d = '0;
`ifdef IIC_NACK_RETRY_EN
                        retry_d      = '0;
`endif
                        if (len != '0) begin
                            len_d   = len;
                            state_d = ST_LOAD;
                        end else begin
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    shreg_d    = tx_data;
`ifdef IIC_NACK_RETRY_EN
                    copy_d     = tx_data;
                    retry_d    = '0;
`endif
                    tx_ready_d = 1'b1;
                    bitcnt_d   = BCNT_W'(DATA_W - 1);
                    armed_d    = 1'b0;
                    state_d    = ST_SHIFT;
                end
                ST_SHIFT: begin
                    // fe is only honoured once this bit was driven, so a
                    // burst entering mid-low-phase waits for a full bit
                    if (scl_fe) begin
                        if (armed_q) begin
                            if (bitcnt_q == '0) begin
                                state_d  = ST_ACK;
                                armed_d  = 1'b0;
                                ackbit_d = 1'b1;
                            end else begin
                                shreg_d  = shreg_q << 1;
                                bitcnt_d = bitcnt_q - BCNT_W'(1);
                            end
                        end
                    end else if (scl_lc && !scl_hc) begin
                        sda_out_d = shreg_q[DATA_W-1];
                        sda_oe_d  = 1'b1;
                        armed_d   = 1'b1;
                    end
                end
                ST_ACK: begin
                    if (scl_fe) begin
                        if (armed_q) begin
                            armed_d = 1'b0;
                            if (!ackbit_q) begin
                                bytes_sent_d = bytes_inc;
                                if (bytes_inc == len_q) begin
                                    done_d  = 1'b1;
                                    state_d = ST_IDLE;
                                end else begin
                                    state_d = ST_LOAD;
                                end
                            end else begin
`ifdef IIC_NACK_RETRY_EN
                                if (retry_q < RETRY_W'(MAX_RETRY)) begin
                                    retry_d  = retry_q + RETRY_W'(1);
                                    shreg_d  = copy_q;
                                    bitcnt_d = BCNT_W'(DATA_W - 1);
                                    state_d  = ST_SHIFT;
                                end else begin
                                    nack_d   = 1'b1;
                                    sda_oe_d = 1'b0;
                                    state_d  = ST_IDLE;
                                end
`else
                                nack_d   = 1'b1;
                                sda_oe_d = 1'b0;
                                state_d  = ST_IDLE;
`endif
                            end
                        end
                    end else if (scl_hc) begin
                        if (armed_q) begin
                            ackbit_d = sda_in;
                        end
                    end else if (scl_lc) begin
                        sda_oe_d = 1'b0;
                        armed_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            armed_q      <= 1'b0;
            ackbit_q     <= 1'b0;
            len_q        <= '0;
            bytes_sent_q <= '0;
            sda_out_q    <= 1'b1;
            sda_oe_q     <= 1'b0;
            tx_ready_q   <= 1'b0;
            done_q       <= 1'b0;
            nack_q       <= 1'b0;
            busy_q       <= 1'b0;
`ifdef IIC_NACK_RETRY_EN
            copy_q       <= '0;
            retry_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            armed_q      <= armed_d;
            ackbit_q     <= ackbit_d;
            len_q        <= len_d;
            bytes_sent_q <= bytes_sent_d;
            sda_out_q    <= sda_out_d;
            sda_oe_q     <= sda_oe_d;
            tx_ready_q   <= tx_ready_d;
            done_q       <= done_d;
            nack_q       <= nack_d;
            busy_q       <= busy_d;
`ifdef IIC_NACK_RETRY_EN
            copy_q       <= copy_d;
            retry_q      <= retry_d;
`endif
        end
    end

    assign tx_ready   = tx_ready_q;
    assign sda_out    = sda_out_q;
    assign sda_oe     = sda_oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign nack       = nack_q;
    assign bytes_sent = bytes_sent_q;

endmodule

// File: tb/tb_iic_tx_ack_engine.sv
// Bench for iic_tx_ack_engine: free-running SCL strobe generator, a slave
// that answers ACK/NACK from a response queue, and a bus monitor that
// rebuilds words from SDA and checks them against a scoreboard filled by a
// burst-level reference model.
`timescale 1ns/1ps
module tb_iic_tx_ack_engine;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MAX_BYTES = 4;
    localparam int unsigned LEN_W     = 3;
    localparam int unsigned MAX_RETRY = 2;
`ifdef IIC_NACK_RETRY_EN
    localparam int RETRIES = MAX_RETRY;
`else
    localparam int RETRIES = 0;
`endif
    localparam int EV_WORD = 0;
    localparam int EV_DONE = 1;
    localparam int EV_NACK = 2;

    typedef struct {
        int          kind;
        int unsigned val;
        int unsigned txr;
    } ev_t;
    typedef logic [DATA_W-1:0] wa_t [MAX_BYTES];
    typedef int na_t [MAX_BYTES];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic [DATA_W-1:0] tx_data = '0;
    logic tx_ready, sda_out, sda_oe, busy, done, nack;
    logic [LEN_W-1:0] bytes_sent;
    logic scl_lc, scl_hc, scl_fe, sda_in;
    logic g_lc = 1'b0, g_hc = 1'b0, g_fe = 1'b0;
    logic m_lc = 1'b0, m_hc = 1'b0, m_fe = 1'b0;
    logic gen_en = 1'b1;
    logic slave_resp = 1'b1;

    ev_t exp_q[$];
    bit  resp_q[$];
    int  total = 0;
    int  bad = 0;
    int  mon_bits = 0;
    int  mon_words = 0;
    int  txr_cnt = 0;
    bit  pend_pop = 1'b0;
    logic prev_lc = 1'b0;
    logic prev_sda = 1'b1;
    logic [DATA_W-1:0] mon_word = '0;

    assign scl_lc = gen_en ? g_lc : m_lc;
    assign scl_hc = gen_en ? g_hc : m_hc;
    assign scl_fe = gen_en ? g_fe : m_fe;
    assign sda_in = sda_oe ? sda_out : slave_resp;

    always #5 clk = ~clk;

    iic_tx_ack_engine #(
        .DATA_W(DATA_W), .MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
        .tx_data(tx_data), .tx_ready(tx_ready), .scl_lc(scl_lc), .scl_hc(scl_hc),
        .scl_fe(scl_fe), .sda_in(sda_in), .sda_out(sda_out), .sda_oe(sda_oe),
        .busy(busy), .done(done), .nack(nack), .bytes_sent(bytes_sent)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic void push_ev(input int k, input int unsigned v, input int unsigned t);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.txr  = t;
        exp_q.push_back(e);
    endfunction

    task automatic expect_ev(input int kind, input logic [31:0] val);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("event_unexpected", 32'(kind), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            if (kind == EV_WORD) begin
                chk("word_value", val, 32'(e.val));
            end else begin
                chk("bytes_sent_at_end", val, 32'(e.val));
                chk("tx_ready_count", 32'(txr_cnt), 32'(e.txr));
            end
        end
    endtask

    // Burst-level reference: each word goes on the bus once per attempt; the
    // slave NACKs the first nk[i] attempts; retries allowed is RETRIES.
    task automatic model(input int l, input wa_t w, input na_t nk);
        int sent, txr, att;
        bit ended;
        sent = 0; txr = 0; ended = 1'b0;
        for (int i = 0; i < l && !ended; i++) begin
            txr++;
            att = 0;
            forever begin
                push_ev(EV_WORD, 32'(w[i]), 0);
                if (att < nk[i]) begin
                    resp_q.push_back(1'b1);
                    if (att < RETRIES) begin
                        att++;
                    end else begin
                        push_ev(EV_NACK, sent, txr);
                        ended = 1'b1;
                        break;
                    end
                end else begin
                    resp_q.push_back(1'b0);
                    sent++;
                    break;
                end
            end
        end
        if (!ended) push_ev(EV_DONE, sent, txr);
        slave_resp = (resp_q.size() > 0) ? resp_q[0] : 1'b1;
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_sda_out"},    32'(sda_out), 32'd1);
        chk({p, "_sda_oe"},     32'(sda_oe), 32'd0);
        chk({p, "_tx_ready"},   32'(tx_ready), 32'd0);
        chk({p, "_done"},       32'(done), 32'd0);
        chk({p, "_nack"},       32'(nack), 32'd0);
        chk({p, "_busy"},       32'(busy), 32'd0);
        chk({p, "_bytes_sent"}, 32'(bytes_sent), 32'd0);
    endtask

    task automatic run_burst(input int l, input wa_t w, input na_t nk, input bit mid_start);
        int  idx;
        bit  seen, restarted;
        model(l, w, nk);
        repeat ($urandom_range(0, 7)) tick();
        tx_data = w[0];
        len     = LEN_W'(l);
        start   = 1'b1;
        tick();
        start = 1'b0;
        idx = 0; seen = 1'b0; restarted = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (tx_ready) begin
                idx++;
                if (idx < l) tx_data = w[idx];
            end
            if (done || nack) begin
                seen = 1'b1;
                break;
            end
            if (mid_start && idx == 1 && !restarted) begin
                len = LEN_W'(1);
                start = 1'b1;
                restarted = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk("burst_end_seen", 32'(seen), 32'd1);
        repeat (20) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("slave_resp_drained", 32'(resp_q.size()), 32'd0);
        chk("idle_after_burst", 32'(busy), 32'd0);
    endtask

    // SCL divider model: fe, lc, hc strobes in an 8-cycle bit period
    initial begin : scl_gen
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % 8;
            g_fe = (ph == 0);
            g_lc = (ph == 2);
            g_hc = (ph == 6);
        end
    end

    // Bus monitor: rebuilds words at SCL-high centres and checks pulses
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_bits = 0;
                pend_pop = 1'b0;
                prev_lc  = 1'b0;
                prev_sda = sda_out;
            end else begin
                if (sda_out !== prev_sda) chk("sda_change_on_lc", 32'(prev_lc), 32'd1);
                prev_sda = sda_out;
                prev_lc  = scl_lc;
                if (start && !busy) txr_cnt = 0;
                if (tx_ready) txr_cnt++;
                if (!busy) begin
                    mon_bits = 0;
                    pend_pop = 1'b0;
                end else if (scl_hc) begin
                    if (mon_bits == DATA_W) begin
                        chk("ack_slot_released", 32'(sda_oe), 32'd0);
                        expect_ev(EV_WORD, 32'(mon_word));
                        mon_words++;
                        mon_bits = 0;
                        pend_pop = 1'b1;
                    end else if (sda_oe) begin
                        mon_word = {mon_word[DATA_W-2:0], sda_out};
                        mon_bits++;
                    end
                end
                if (scl_fe && pend_pop) begin
                    if (resp_q.size() > 0) void'(resp_q.pop_front());
                    pend_pop = 1'b0;
                    slave_resp = (resp_q.size() > 0) ? resp_q[0] : 1'b1;
                end
                if (done || nack) begin
                    chk("done_nack_exclusive", 32'(done & nack), 32'd0);
                    expect_ev(done ? EV_DONE : EV_NACK, 32'(bytes_sent));
                end
            end
        end
    end

    initial begin : stim
        wa_t w;
        na_t nk;
        int  base;
        bit  ok;

        repeat (3) tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (4) tick();

        // Single word A5, slave ACKs
        w = '{8'hA5, 8'h00, 8'h00, 8'h00}; nk = '{0, 0, 0, 0};
        run_burst(1, w, nk, 1'b0);
        chk("a5_bytes_sent", 32'(bytes_sent), 32'd1);

        // Three words, all ACKed
        w = '{8'h80, 8'h01, 8'hFF, 8'h00};
        run_burst(3, w, nk, 1'b0);
        chk("three_bytes_sent", 32'(bytes_sent), 32'd3);

        // Second word NACKed once
        w = '{8'h5A, 8'hC3, 8'h00, 8'h00}; nk = '{0, 1, 0, 0};
        run_burst(2, w, nk, 1'b0);

        // Second word NACKed twice then ACKed
        nk = '{0, 2, 0, 0};
        run_burst(2, w, nk, 1'b0);

        // Zero-length burst: done only
        nk = '{0, 0, 0, 0};
        run_burst(0, w, nk, 1'b0);
        chk("len0_bytes_sent", 32'(bytes_sent), 32'd0);

        // Randomised bursts, some with a start pulse issued while busy
        for (int b = 0; b < 30; b++) begin
            for (int i = 0; i < MAX_BYTES; i++) begin
                w[i]  = DATA_W'($urandom);
                nk[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MAX_RETRY + 1)) : 0;
            end
            run_burst(int'($urandom_range(0, MAX_BYTES)), w, nk, 1'($urandom_range(0, 1)));
        end

        // Abort during bit 4 of the second word
        push_ev(EV_WORD, 32'h11, 0);
        resp_q.push_back(1'b0);
        slave_resp = 1'b0;
        base = mon_words;
        tx_data = 8'h11; len = LEN_W'(2); start = 1'b1;
        tick();
        start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (tx_ready) tx_data = 8'h22;
            if (mon_words >= base + 1 && mon_bits == 4) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("abort_reached_bit4", 32'(ok), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sda_oe", 32'(sda_oe), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_nack", 32'(nack), 32'd0);
        chk("abort_bytes_held", 32'(bytes_sent), 32'd1);
        repeat (40) tick();
        chk("abort_scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // fe together with lc: fe wins, bit advances, lc is dropped
        gen_en = 1'b0;
        tx_data = 8'hA5; len = LEN_W'(1); start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        m_lc = 1'b1; tick(); m_lc = 1'b0; tick();
        chk("collide_first_oe", 32'(sda_oe), 32'd1);
        chk("collide_first_bit", 32'(sda_out), 32'd1);
        m_hc = 1'b1; tick(); m_hc = 1'b0;
        m_fe = 1'b1; m_lc = 1'b1; tick(); m_fe = 1'b0; m_lc = 1'b0; tick();
        chk("collide_sda_held", 32'(sda_out), 32'd1);
        m_lc = 1'b1; tick(); m_lc = 1'b0; tick();
        chk("collide_bit_advanced", 32'(sda_out), 32'd0);
        abort = 1'b1; tick(); abort = 1'b0;
        gen_en = 1'b1;
        repeat (4) tick();

        // Reset asserted in the ACK slot of the second word
        push_ev(EV_WORD, 32'h3C, 0);
        resp_q.push_back(1'b0);
        slave_resp = 1'b0;
        base = mon_words;
        tx_data = 8'h3C; len = LEN_W'(2); start = 1'b1;
        tick();
        start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (tx_ready) tx_data = 8'hC3;
            if (mon_words >= base + 1 && mon_bits == DATA_W && !sda_oe) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("rst_reached_ack", 32'(ok), 32'd1);
        chk("rst_pre_bytes_sent", 32'(bytes_sent), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("rst_mid_ack");
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("rst_scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Normal burst after reset
        w = '{8'hE7, 8'h18, 8'h00, 8'h00}; nk = '{0, 0, 0, 0};
        run_burst(2, w, nk, 1'b0);
        chk("post_rst_bytes_sent", 32'(bytes_sent), 32'd2);

        repeat (10) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
